rv32i_multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle RV32I `control` unit. A Moore/Mealy FSM sequences FETCH, DECODE, EXECUTE, MEM and WB over shared memory and a shared ALU.
- Adds three things: a memory ready handshake, an optional extended ALU op set, and a sticky illegal-instruction trap.
- Also adds a retired-instruction counter.
- Sits between the instruction register/register file/ALU datapath and a single unified memory port.

---
 rtl/rv32i_multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_rv32i_multicycle_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port and shared ALU, with memory ready handshake, trap state and retire counter.
module rv32i_multicycle_control #(
  parameter int EXT_ALU    = 0,
  parameter int ALU_CTRL_W = 3,
  parameter int RET_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op_code,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_type,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_instr,
  output logic                  retired,
  output logic [RET_CNT_W-1:0]  ret_count
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BRANCH, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  state_t     state;
  logic [4:0] r_dec;
  logic [4:0] i_dec;
  logic       unused_func7;

  // Returns {legal, alu_op}; SUB only exists for register-register forms.
  function automatic logic [4:0] alu_dec(input logic [2:0] f3, input logic f7_5,
                                         input logic is_r);
    logic       legal;
    logic [3:0] op;
    legal = 1'b1;
    op    = ALU_ADD;
    case (f3)
      3'b000: op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b010: op = 4'd5;
      3'b110: op = 4'd3;
      3'b111: op = 4'd2;
      3'b100: begin op = 4'd4; legal = (EXT_ALU != 0); end
      3'b001: begin op = 4'd6; legal = (EXT_ALU != 0); end
      3'b101: begin op = f7_5 ? 4'd8 : 4'd7; legal = (EXT_ALU != 0); end
      3'b011: begin op = 4'd9; legal = (EXT_ALU != 0); end
      default: legal = 1'b0;
    endcase
    return {legal, op};
  endfunction

  assign r_dec        = alu_dec(func3, func7[5], 1'b1);
  assign i_dec        = alu_dec(func3, func7[5], 1'b0);
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_count <= '0;
    end else begin
      if (retired) ret_count <= ret_count + RET_CNT_W'(1);
      case (state)
        IDLE:     state <= FETCH;
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op_code)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_ALU_R:          state <= r_dec[4] ? EXECR : TRAP;
            OP_ALU_I:          state <= i_dec[4] ? EXECI : TRAP;
            OP_JAL:            state <= JAL;
            OP_BRANCH:         state <= (func3[2:1] == 2'b00) ? BRANCH : TRAP;
            default:           state <= TRAP;
          endcase
        end
        MEMADR:   state <= (op_code == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        JAL:      state <= ALUWB;
        BRANCH:   state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode from the state register; mem_ready and zero add the Mealy terms.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_CTRL_W'(ALU_ADD);
    illegal_instr = 1'b0;
    retired       = 1'b0;
    case (op_code)
      OP_STORE:  imm_type = 3'b001;
      OP_BRANCH: imm_type = 3'b010;
      OP_JAL:    imm_type = 3'b011;
      default:   imm_type = 3'b000;
    endcase
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retired    = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retired   = mem_ready;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_CTRL_W'(r_dec[3:0]);
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = ALU_CTRL_W'(i_dec[3:0]);
      end
      ALUWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_CTRL_W'(ALU_SUB);
        pc_write    = zero ^ func3[0];
        retired     = 1'b1;
      end
      TRAP:    illegal_instr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Directed bench for rv32i_multicycle_control: base instance plus an EXT_ALU instance
// sharing the same stimulus.
module tb_rv32i_multicycle_control;
  logic clk, rst_n;
  logic [6:0] op_code, func7;
  logic [2:0] func3;
  logic zero, mem_ready;

  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr, retired;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_type, alu_control;
  logic [31:0] ret_count;

  logic mem_req_x, mem_write_x, adr_src_x, ir_write_x, pc_write_x, reg_write_x;
  logic illegal_instr_x, retired_x;
  logic [1:0] result_src_x, alu_src_a_x, alu_src_b_x;
  logic [2:0] imm_type_x;
  logic [3:0] alu_control_x;
  logic [31:0] ret_count_x;

  int total = 0;
  int bad = 0;

  rv32i_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_type(imm_type), .alu_control(alu_control), .illegal_instr(illegal_instr),
    .retired(retired), .ret_count(ret_count)
  );

  rv32i_multicycle_control #(.EXT_ALU(1), .ALU_CTRL_W(4), .RET_CNT_W(32)) dut_x (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req_x), .mem_write(mem_write_x),
    .adr_src(adr_src_x), .ir_write(ir_write_x), .pc_write(pc_write_x),
    .reg_write(reg_write_x), .result_src(result_src_x), .alu_src_a(alu_src_a_x),
    .alu_src_b(alu_src_b_x), .imm_type(imm_type_x), .alu_control(alu_control_x),
    .illegal_instr(illegal_instr_x), .retired(retired_x), .ret_count(ret_count_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #4;
  endtask

  // Holds reset for one edge, checks the reset state, then releases away from the edge.
  task automatic start(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic rdy, input logic z);
    op_code = op; func3 = f3; func7 = f7; mem_ready = rdy; zero = z;
    rst_n = 1'b0;
    cyc();
    chk("rst_ret_count", ret_count, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_illegal", {31'd0, illegal_instr}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; op_code = '0; func3 = '0; func7 = '0; zero = 1'b0; mem_ready = 1'b0;

    // LW, mem_ready tied high
    start(7'b0000011, 3'b010, 7'd0, 1'b1, 1'b0);
    chk("lw_idle_mem_req", {31'd0, mem_req}, 0);
    chk("lw_idle_alu", {29'd0, alu_control}, 0);
    chk("lw_idle_pc_write", {31'd0, pc_write}, 0);
    cyc();
    chk("lw_fetch_mem_req", {31'd0, mem_req}, 1);
    chk("lw_fetch_ir_write", {31'd0, ir_write}, 1);
    chk("lw_fetch_pc_write", {31'd0, pc_write}, 1);
    chk("lw_fetch_src_b", {30'd0, alu_src_b}, 2);
    chk("lw_fetch_result_src", {30'd0, result_src}, 2);
    cyc();
    chk("lw_decode_src_a", {30'd0, alu_src_a}, 1);
    chk("lw_decode_mem_req", {31'd0, mem_req}, 0);
    cyc();
    chk("lw_memadr_src_a", {30'd0, alu_src_a}, 2);
    chk("lw_memadr_alu", {29'd0, alu_control}, 0);
    chk("lw_memadr_imm", {29'd0, imm_type}, 0);
    cyc();
    chk("lw_memread_req", {30'd0, mem_req, adr_src}, 3);
    chk("lw_memread_write", {31'd0, mem_write}, 0);
    cyc();
    chk("lw_memwb_reg_write", {31'd0, reg_write}, 1);
    chk("lw_memwb_result_src", {30'd0, result_src}, 1);
    chk("lw_memwb_retired", {31'd0, retired}, 1);
    cyc();
    chk("lw_after_ret_count", ret_count, 1);
    chk("lw_after_retired", {31'd0, retired}, 0);

    // SW with three wait cycles in MEMWRITE
    start(7'b0100011, 3'b010, 7'd0, 1'b1, 1'b0);
    cyc(); cyc();
    chk("sw_decode_imm", {29'd0, imm_type}, 1);
    cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sw_wait_strobes", {30'd0, mem_req, mem_write}, 3);
      chk("sw_wait_reg_write", {31'd0, reg_write}, 0);
      chk("sw_wait_retired", {31'd0, retired}, 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_ready_strobes", {30'd0, mem_req, mem_write}, 3);
    chk("sw_ready_retired", {31'd0, retired}, 1);
    chk("sw_ready_reg_write", {31'd0, reg_write}, 0);
    cyc();
    chk("sw_after_mem_write", {31'd0, mem_write}, 0);
    chk("sw_after_ret_count", ret_count, 1);

    // Second SW aborted by reset during the MEMWRITE wait
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    chk("abort_pre_mem_write", {31'd0, mem_write}, 1);
    chk("abort_pre_ret_count", ret_count, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'd0, mem_write}, 0);
    chk("abort_mem_req", {31'd0, mem_req}, 0);
    chk("abort_ret_count", ret_count, 0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    chk("abort_idle_mem_req", {31'd0, mem_req}, 0);
    cyc();
    chk("abort_fetch_mem_req", {31'd0, mem_req}, 1);
    chk("abort_fetch_adr_src", {31'd0, adr_src}, 0);

    // R-type SUB
    start(7'b0110011, 3'b000, 7'b0100000, 1'b1, 1'b0);
    cyc(); cyc(); cyc();
    chk("sub_execr_alu", {29'd0, alu_control}, 1);
    chk("sub_execr_srcs", {28'd0, alu_src_a, alu_src_b}, 4'b1000);
    cyc();
    chk("sub_aluwb_reg_write", {31'd0, reg_write}, 1);
    chk("sub_aluwb_alu", {29'd0, alu_control}, 0);
    chk("sub_aluwb_retired", {31'd0, retired}, 1);

    // I-type ORI (func7[5] must not matter)
    start(7'b0010011, 3'b110, 7'b0100000, 1'b1, 1'b0);
    cyc(); cyc(); cyc();
    chk("ori_execi_alu", {29'd0, alu_control}, 3);
    chk("ori_execi_src_b", {30'd0, alu_src_b}, 1);

    // BEQ/BNE resolution in BRANCH
    start(7'b1100011, 3'b000, 7'd0, 1'b1, 1'b1);
    cyc(); cyc();
    chk("br_decode_imm", {29'd0, imm_type}, 2);
    cyc();
    chk("beq_taken_pc_write", {31'd0, pc_write}, 1);
    chk("br_alu_sub", {29'd0, alu_control}, 1);
    chk("br_retired", {31'd0, retired}, 1);
    zero = 1'b0;
    #1;
    chk("beq_not_taken_pc_write", {31'd0, pc_write}, 0);
    func3 = 3'b001;
    #1;
    chk("bne_taken_pc_write", {31'd0, pc_write}, 1);
    cyc();
    chk("br_after_ret_count", ret_count, 1);
    chk("br_after_mem_req", {31'd0, mem_req}, 1);

    // JAL
    start(7'b1101111, 3'b000, 7'd0, 1'b1, 1'b0);
    cyc(); cyc();
    chk("jal_decode_imm", {29'd0, imm_type}, 3);
    cyc();
    chk("jal_pc_write", {31'd0, pc_write}, 1);
    chk("jal_srcs", {28'd0, alu_src_a, alu_src_b}, 4'b0110);
    chk("jal_reg_write", {31'd0, reg_write}, 0);
    cyc();
    chk("jal_aluwb_reg_write", {31'd0, reg_write}, 1);

    // XOR: trap without EXT_ALU, decoded with it
    start(7'b0110011, 3'b100, 7'd0, 1'b1, 1'b0);
    cyc(); cyc();
    chk("xor_decode_illegal", {31'd0, illegal_instr}, 0);
    cyc();
    chk("xor_ext_alu", {28'd0, alu_control_x}, 4);
    for (int i = 0; i < 3; i++) begin
      chk("trap_illegal", {31'd0, illegal_instr}, 1);
      chk("trap_mem_req", {31'd0, mem_req}, 0);
      chk("trap_writes", {29'd0, reg_write, pc_write, mem_write}, 0);
      chk("trap_ret_count", ret_count, 0);
      cyc();
    end
    chk("xor_ext_ret_count", ret_count_x, 1);
    chk("xor_ext_illegal", {31'd0, illegal_instr_x}, 0);

    // SRAI with EXT_ALU; base instance traps
    start(7'b0010011, 3'b101, 7'b0100000, 1'b1, 1'b0);
    cyc(); cyc(); cyc();
    chk("srai_ext_alu", {28'd0, alu_control_x}, 8);
    chk("srai_base_illegal", {31'd0, illegal_instr}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
